// File: rtl/rr_shi_seq.sv
// rr_shi_seq: command sequencer driving the 256-bit load/shift register (load, bit-shift, rotate-unload, clear)
module rr_shi_seq #(
  parameter int WORDS = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             shift_bit,
  output logic             shift_req,
  output logic             shift_out,
  output logic             done,
  output logic [31:0]      sr_regin,
  output logic             sr_we,
  output logic             sr_sel_rs,
  output logic             sr_bit256,
  output logic             sr_set,
  input  logic [31:0]      sr_regout
);
  localparam int WW = $clog2(WORDS);
  localparam logic [CNT_W-1:0] MAXB = CNT_W'(WORDS * 32);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UNLOAD, CLEAR} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;
  logic done_n, in_hs, out_hs, last_w;
  assign in_hs  = state == LOAD && in_valid;
  assign out_hs = state == UNLOAD && out_ready;
  assign last_w = wcnt == WW'(WORDS - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      bcnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      bcnt  <= bcnt_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    done_n  = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        wcnt_n  = '0;
        bcnt_n  = cmd_arg > MAXB ? MAXB : cmd_arg;
        state_n = cmd == 2'b00 ? LOAD : cmd == 2'b01 ? (cmd_arg == '0 ? IDLE : SHIFT) : cmd == 2'b10 ? UNLOAD : CLEAR;
        done_n  = cmd == 2'b01 && cmd_arg == '0;
      end
      LOAD, UNLOAD: if (in_hs || out_hs) begin
        wcnt_n  = wcnt + 1'b1;
        state_n = last_w ? IDLE : state;
        done_n  = last_w;
      end
      SHIFT: begin
        bcnt_n  = bcnt - 1'b1;
        state_n = bcnt == CNT_W'(1) ? IDLE : SHIFT;
        done_n  = bcnt == CNT_W'(1);
      end
      CLEAR: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign cmd_ready = state == IDLE;
  assign in_ready  = state == LOAD;
  assign out_valid = state == UNLOAD;
  assign out_data  = out_valid ? sr_regout : '0;
  assign shift_req = state == SHIFT;
  assign shift_out = shift_req & sr_regout[0];
  assign sr_we     = in_hs | out_hs | shift_req | (state == CLEAR);
  assign sr_sel_rs = shift_req;
  assign sr_bit256 = shift_req & shift_bit;
  assign sr_set    = state == CLEAR;
  assign sr_regin  = in_hs ? in_data : out_hs ? sr_regout : '0;
endmodule
